// File: rtl/block_store_fsm_pkg.sv
// Shared definitions for the block fetch/store sequencers: register count, widths and state encoding.
package block_store_fsm_pkg;

   localparam int SEQ_DATA_WIDTH = 16;
   localparam int SEQ_ADDR_WIDTH = 16;
   localparam int SEQ_NUM_REGS   = 8;
   localparam int SEQ_IDX_WIDTH  = $clog2(SEQ_NUM_REGS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } seq_state_t;

endpackage

// File: rtl/block_store_fsm.sv
// Writes r0..r7 to base..base+7 in 8 cycles plus stalls, then a 1-cycle done pulse.
// A write is held with all outputs stable while mem_ready is low; no limit on stall length.
module block_store_fsm
   import block_store_fsm_pkg::*;
#(
   parameter int DATA_WIDTH = SEQ_DATA_WIDTH,
   parameter int ADDR_WIDTH = SEQ_ADDR_WIDTH,
   parameter int NUM_REGS   = SEQ_NUM_REGS,
   localparam int IDX_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_address,
   output logic [IDX_WIDTH-1:0]  reg_sel,
   input  logic [DATA_WIDTH-1:0] reg_rdata,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ready,
   output logic                  block_store,
   output logic                  done
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REGS - 1);

   seq_state_t            state_q, state_d;
   logic [IDX_WIDTH-1:0]  idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      base_d  = base_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               base_d  = base_address;
               idx_d   = '0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (mem_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + IDX_WIDTH'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control outputs come from registered state only; only write data passes through combinationally.
   assign mem_we      = (state_q == WRITE);
   assign reg_sel     = idx_q;
   assign mem_addr    = base_q + ADDR_WIDTH'(idx_q);
   assign mem_wdata   = reg_rdata;
   assign block_store = (state_q != IDLE);
   assign done        = (state_q == DONE);

endmodule
